// File: rtl/i2s_tx_serializer_pkg.sv
// Shared synth constants and the stereo frame type used by the I2S transmit path.
package i2s_tx_serializer_pkg;

  localparam int I2S_AUD_BITS  = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_DIV  = 4;
  localparam int FRAME_CYCLES  = I2S_BCLK_DIV * 2 * I2S_SLOT_BITS;

  typedef struct packed {
    logic [I2S_AUD_BITS-1:0] left;
    logic [I2S_AUD_BITS-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample hand-off between the synth engine and the I2S serializer.
interface i2s_tx_serializer_if
  import i2s_tx_serializer_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = I2S_AUD_BITS
);

  // sample_strobe is a one-cycle valid with no ready: the serializer always
  // accepts it (a second strobe before use overwrites). trig is a one-cycle
  // request for the next sample, issued at each frame start.
  logic                     sample_strobe;
  logic [AUD_BIT_DEPTH-1:0] lsound_in;
  logic [AUD_BIT_DEPTH-1:0] rsound_in;
  logic                     trig;

  modport master (
    output sample_strobe,
    output lsound_in,
    output rsound_in,
    input  trig
  );

  modport slave (
    input  sample_strobe,
    input  lsound_in,
    input  rsound_in,
    output trig
  );

endinterface

// File: rtl/i2s_tx_serializer_bit_timer.sv
// BCLK divider and bit position counter; produces BCLK/LRCK and the falling-edge strobes.
module i2s_bit_timer #(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4,
  parameter int BIT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             fall_edge,
  output logic             frame_start,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             i2s_bclk,
  output logic             i2s_lrck
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] BCLK_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] BCLK_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_POS  = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] bclk_cnt;

  assign fall_edge   = enable && (bclk_cnt == '0);
  assign frame_start = fall_edge && (bit_cnt == '0);

  // While disabled the position is frozen and BCLK parks low, so resuming
  // continues the same bit without a spurious rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_cnt <= '0;
      bit_cnt  <= '0;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
    end else if (!enable) begin
      i2s_bclk <= 1'b0;
    end else begin
      i2s_bclk <= (bclk_cnt >= BCLK_HALF);
      if (bclk_cnt == '0) begin
        i2s_lrck <= (bit_cnt >= SLOT_POS);
      end
      if (bclk_cnt == BCLK_LAST) begin
        bclk_cnt <= '0;
        bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        bclk_cnt <= bclk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Double-buffered I2S transmitter: captures engine samples, serializes them MSB first
// with the one-BCLK I2S delay, and requests the next sample once per frame.
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = I2S_AUD_BITS,
  parameter int SLOT_BITS     = I2S_SLOT_BITS,
  parameter int BCLK_DIV      = I2S_BCLK_DIV,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 AUDIO_CLK,
  input  logic                 reset_data,
  input  logic                 enable,
  i2s_tx_serializer_if.slave   snd,
  output logic                 i2s_bclk,
  output logic                 i2s_lrck,
  output logic                 i2s_sdata,
  output logic [CNT_WIDTH-1:0] underrun_cnt,
  output logic [CNT_WIDTH-1:0] overrun_cnt
);

  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [BIT_W-1:0]     SLOT_POS = BIT_W'(SLOT_BITS);

  logic                     fall_edge;
  logic                     frame_start;
  logic [BIT_W-1:0]         bit_cnt;
  i2s_frame_t               pend_buf;
  i2s_frame_t               frame_buf;
  logic                     pend_valid;
  logic                     trig_q;
  logic                     sdata_q;
  logic                     is_right;
  logic [BIT_W-1:0]         slot_pos;
  logic [AUD_BIT_DEPTH-1:0] chan;
  logic                     next_bit;

  i2s_bit_timer #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV),
    .BIT_W     (BIT_W)
  ) u_bit_timer (
    .clk         (AUDIO_CLK),
    .rst         (reset_data),
    .enable      (enable),
    .fall_edge   (fall_edge),
    .frame_start (frame_start),
    .bit_cnt     (bit_cnt),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck)
  );

  // Slot position 0 carries the I2S delay bit; positions past the sample are padding.
  always_comb begin
    is_right = (bit_cnt >= SLOT_POS);
    slot_pos = is_right ? (bit_cnt - SLOT_POS) : bit_cnt;
    chan     = is_right ? frame_buf.right : frame_buf.left;
    next_bit = 1'b0;
    for (int k = 0; k < AUD_BIT_DEPTH; k++) begin
      if (slot_pos == BIT_W'(AUD_BIT_DEPTH - k)) begin
        next_bit = chan[k];
      end
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      pend_buf     <= '0;
      frame_buf    <= '0;
      pend_valid   <= 1'b0;
      trig_q       <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      trig_q <= frame_start;
      if (fall_edge) begin
        sdata_q <= next_bit;
      end
      if (frame_start) begin
        if (pend_valid) begin
          frame_buf <= pend_buf;
        end else if (underrun_cnt != CNT_MAX) begin
          underrun_cnt <= underrun_cnt + 1'b1;
        end
      end
      // A strobe on the frame-start cycle lands after the frame has taken the
      // old contents, so it is a fresh sample rather than an overwrite.
      if (snd.sample_strobe) begin
        pend_buf.left  <= snd.lsound_in;
        pend_buf.right <= snd.rsound_in;
        pend_valid     <= 1'b1;
        if (pend_valid && !frame_start && enable && (overrun_cnt != CNT_MAX)) begin
          overrun_cnt <= overrun_cnt + 1'b1;
        end
      end else if (frame_start) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign snd.trig  = trig_q;
  assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: frame-level reference model feeding a scoreboard
// that is checked against frames deserialized from the DUT's I2S pins.
module tb_i2s_tx_serializer;
  import i2s_tx_serializer_pkg::*;

  localparam int AW      = I2S_AUD_BITS;
  localparam int FB      = 2 * I2S_SLOT_BITS;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [FB-1:0] LRCK_PAT = {{I2S_SLOT_BITS{1'b0}}, {I2S_SLOT_BITS{1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic             i2s_bclk, i2s_lrck, i2s_sdata;
  logic [CNT_W-1:0] underrun_cnt, overrun_cnt;

  i2s_tx_serializer_if #(.AUD_BIT_DEPTH(AW)) sif ();

  i2s_tx_serializer #(
    .AUD_BIT_DEPTH (AW),
    .SLOT_BITS     (I2S_SLOT_BITS),
    .BCLK_DIV      (I2S_BCLK_DIV),
    .CNT_WIDTH     (CNT_W)
  ) dut (
    .AUDIO_CLK    (clk),
    .reset_data   (rst),
    .enable       (enable),
    .snd          (sif.slave),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int frames_checked = 0;
  logic [FB-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected 64-bit frame, first transmitted bit at the MSB.
  function automatic logic [FB-1:0] frame_word(input logic [AW-1:0] l, input logic [AW-1:0] r);
    logic [FB-1:0] w;
    w = '0;
    for (int p = 0; p < FB; p++) begin
      int s;
      s = p % I2S_SLOT_BITS;
      if (s >= 1 && s <= AW) w[FB-1-p] = (p < I2S_SLOT_BITS) ? l[AW-s] : r[AW-s];
    end
    return w;
  endfunction

  // ---------------- reference model ----------------
  // Position is just the number of enabled cycles since reset; a frame starts
  // every FRAME_CYCLES of them.
  int            e = 0;
  logic          m_trig = 1'b0;
  logic          m_pend_v = 1'b0;
  logic [AW-1:0] m_pend_l = '0, m_pend_r = '0, m_frm_l = '0, m_frm_r = '0;
  int            m_und = 0, m_ovr = 0;

  always @(posedge clk) begin
    if (rst) begin
      e = 0; m_trig = 1'b0; m_pend_v = 1'b0;
      m_pend_l = '0; m_pend_r = '0; m_frm_l = '0; m_frm_r = '0;
      m_und = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      m_trig = enable && ((e % FRAME_CYCLES) == 0);
      if (m_trig) begin
        if (m_pend_v) begin
          m_frm_l = m_pend_l;
          m_frm_r = m_pend_r;
        end else if (m_und < CNT_MAX) begin
          m_und++;
        end
        m_pend_v = 1'b0;
        exp_q.push_back(frame_word(m_frm_l, m_frm_r));
      end
      if (sif.sample_strobe) begin
        if (m_pend_v && enable && m_ovr < CNT_MAX) m_ovr++;
        m_pend_l = sif.lsound_in;
        m_pend_r = sif.rsound_in;
        m_pend_v = 1'b1;
      end
      if (enable) e++;
    end
  end

  // ---------------- monitor ----------------
  int            cap_n = 0;
  logic [FB-1:0] cap_d = '0, cap_l = '0, exp_w;
  logic          prev_bclk = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("reset_outputs",
            64'({sif.trig, i2s_bclk, i2s_lrck, i2s_sdata, underrun_cnt, overrun_cnt}), 64'd0);
      cap_n = 0;
      prev_bclk = 1'b0;
    end else begin
      if (sif.trig || m_trig) check("trig", 64'(sif.trig), 64'(m_trig));
      if (!enable) check("idle_bclk_trig", 64'({i2s_bclk, sif.trig}), 64'd0);
      if (!prev_bclk && i2s_bclk) begin
        cap_d = {cap_d[FB-2:0], i2s_sdata};
        cap_l = {cap_l[FB-2:0], i2s_lrck};
        cap_n++;
        if (cap_n == FB) begin
          cap_n = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got %h expected none at %0t", cap_d, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame_data", cap_d, exp_w);
            check("frame_lrck", cap_l, LRCK_PAT);
            check("underrun_cnt", 64'(underrun_cnt), 64'(m_und));
            check("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
            frames_checked++;
          end
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_strobe(input logic [AW-1:0] l, input logic [AW-1:0] r);
    sif.lsound_in     = l;
    sif.rsound_in     = r;
    sif.sample_strobe = 1'b1;
    @(negedge clk);
    sif.sample_strobe = 1'b0;
  endtask

  // Returns at the negedge just before the edge at frame position p.
  task automatic wait_pos(input int p);
    int k;
    k = 0;
    @(negedge clk);
    while ((e % FRAME_CYCLES) != p) begin
      @(negedge clk);
      k++;
      if (k > 2 * FRAME_CYCLES) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos timeout: got pos %0d expected %0d", e % FRAME_CYCLES, p);
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sif.sample_strobe = 1'b0;
    sif.lsound_in     = '0;
    sif.rsound_in     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;

    // No samples: silent frames, underrun climbs and saturates.
    repeat (18 * FRAME_CYCLES) @(negedge clk);

    do_reset(2);
    // Fixed pattern once per frame.
    repeat (3) begin
      wait_pos(40);
      do_strobe(24'hA50F3C, 24'h800001);
    end

    // Two strobes in one frame: the second wins, one overrun.
    wait_pos(8);
    do_strobe(24'h000001, 24'h111111);
    repeat (30) @(negedge clk);
    do_strobe(24'h000002, 24'h222222);

    // Strobe on the frame-start cycle itself.
    wait_pos(100);
    do_strobe(24'h123456, 24'h654321);
    wait_pos(0);
    do_strobe(24'hFEDCBA, 24'h0F0F0F);
    wait_pos(100);
    do_strobe(AW'($urandom), AW'($urandom));

    // Pause mid-slot with BCLK low; the stream must resume seamlessly.
    wait_pos(42);
    enable = 1'b0;
    repeat (50) @(negedge clk);
    enable = 1'b1;

    // Reset in the middle of bit 40.
    wait_pos(100);
    do_strobe(AW'($urandom), AW'($urandom));
    wait_pos(160);
    do_reset(2);

    // Random strobe timing and data.
    repeat (12 * FRAME_CYCLES) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) do_strobe(AW'($urandom), AW'($urandom));
    end

    repeat (2 * FRAME_CYCLES + 8) @(negedge clk);
    check("frames_seen_min", 64'(frames_checked >= 30), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Downstream stage of the synthesizer engine. Captures the 24-bit left/right samples presented once per sample period and serializes them as a standard I2S stream (BCLK, LRCK, SDATA) to the codec. Also generates the per-frame `trig` pulse that starts the engine's next sample computation, so the engine and the codec frame stay locked. Double-buffered, with underrun/overrun detection.

Parameters:
AUD_BIT_DEPTH, 24, sample width; must be less than SLOT_BITS.
SLOT_BITS, 32, BCLK periods per channel slot.
BCLK_DIV, 4, AUDIO_CLK cycles per BCLK period; even, at least 2.
CNT_WIDTH, 8, width of the saturating underrun/overrun counters.

Ports:
AUDIO_CLK  in  1  sole clock.
reset_data  in  1  synchronous reset, active-high.
enable  in  1  0 = outputs held idle, counters frozen.
sample_strobe  in  1  one-cycle pulse: lsound_in/rsound_in valid (driven from the engine's xxxx_zero).
lsound_in  in  AUD_BIT_DEPTH  left sample, two's complement.
rsound_in  in  AUD_BIT_DEPTH  right sample, two's complement.
trig  out  1  one-cycle pulse at each frame start; requests the next sample.
i2s_bclk  out  1  bit clock.
i2s_lrck  out  1  word select: 0 = left, 1 = right.
i2s_sdata  out  1  serial data, MSB first.
underrun_cnt  out  CNT_WIDTH  frames sent without a fresh sample; saturating.
overrun_cnt  out  CNT_WIDTH  samples overwritten before use; saturating.

Behaviour:
- Reset (reset_data=1 at an AUDIO_CLK edge) clears, with priority over all else:
  - all outputs to 0;
  - bclk_cnt, bit_cnt, pending buffer, frame buffer, pending_valid.
  - Reset mid-frame aborts the frame immediately. The next frame starts at bit_cnt=0 on the first enabled cycle after reset.
- Counters:
  - bclk_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk = 0 while bclk_cnt < BCLK_DIV/2, else 1 (registered).
  - bit_cnt counts 0..2*SLOT_BITS-1; it advances when bclk_cnt wraps to 0, i.e. at the BCLK falling edge.
- Outputs change only at the falling edge. Registered on the cycle where bclk_cnt becomes 0:
  - i2s_lrck = (bit_cnt >= SLOT_BITS).
  - Slot position s = bit_cnt mod SLOT_BITS.
  - i2s_sdata = channel bit [AUD_BIT_DEPTH-s] for 1 ≤ s ≤ AUD_BIT_DEPTH, otherwise 0. This gives the I2S one-BCLK MSB delay and zero padding.
- Frame start is bit_cnt=0 with bclk_cnt=0. On that cycle:
  - Frame buffer ← pending buffer if pending_valid; otherwise the frame buffer is retained (previous sample repeats) and underrun_cnt increments.
  - pending_valid ← 0.
  - trig = 1 for exactly this one cycle.
- Pending buffer:
  - sample_strobe loads both channels and sets pending_valid.
  - Strobe while pending_valid=1: overwrite the buffer, increment overrun_cnt.
  - Strobe in the same cycle as the frame start: the frame takes the old pending contents, then the new sample is loaded and pending_valid stays 1. No overrun is counted.
- Latency: a sample strobed during frame N is transmitted in frame N+1.
  - MSB of left appears at the falling edge of bit_cnt=1.
  - MSB of right appears at bit_cnt=SLOT_BITS+1.
- Counters saturate at 2^CNT_WIDTH-1 and clear only on reset.
- enable=0:
  - all counters hold, i2s_bclk held 0, trig suppressed;
  - sample_strobe is still accepted into the pending buffer.
  - Re-enable resumes from the held state.
- Frame period = BCLK_DIV*2*SLOT_BITS AUDIO_CLK cycles (256 with defaults).

Decomposition:
- The shared synth package holds:
  - `i2s_frame_t`, a struct of left/right logic [AUD_BIT_DEPTH-1:0];
  - constants `I2S_SLOT_BITS`, `I2S_BCLK_DIV`, and `FRAME_CYCLES = I2S_BCLK_DIV*2*I2S_SLOT_BITS`.
- One sub-module, `i2s_bit_timer`: bclk_cnt, bit_cnt, i2s_bclk/i2s_lrck generation, and the fall_edge / frame_start strobes.
- Buffering, bit selection and counters stay in the top module.

Test Plan:
1. Reset then enable=1, no strobes: trig pulses every 256 cycles; i2s_lrck toggles every 128 cycles; i2s_sdata is always 0; underrun_cnt = 1, 2, 3… up to 255 and holds.
2. Strobe L=24'hA50F3C, R=24'h800001 once per frame:
   - next frame's left slot bits 1..24 read A50F3C MSB-first, bits 25..31 read 0;
   - right slot bits 1..24 read 800001;
   - underrun_cnt stops incrementing.
3. Two strobes in one frame (L=1, then L=2): next frame sends L=2; overrun_cnt = 1.
4. Strobe coincident with the frame-start cycle: the current frame uses the prior sample, the next frame uses the new one; overrun_cnt is unchanged.
5. Assert reset_data at bit_cnt=40: the next cycle has all outputs at 0; after release, the first trig comes exactly 1 cycle after the first enabled cycle and the counters read 0.
6. Drop enable for 50 cycles mid-slot: i2s_bclk stays 0, no trig, bit position is preserved; after re-enable the stream continues with no lost or duplicated bit.
